// File: rtl/custom_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : custom_unit_pkg
//  Purpose  : Shared mode encodings and sizing helpers for the pipelined
//             Versat custom reduction unit.
//  Revision : 1.0 - initial pipelined release
// ============================================================================
package custom_unit_pkg;

    localparam logic [1:0] MODE_SUM = 2'd0;
    localparam logic [1:0] MODE_XOR = 2'd1;
    localparam logic [1:0] MODE_ACC = 2'd2;
    localparam logic [1:0] MODE_SUB = 2'd3;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Input-to-out0 latency in running cycles: one register per tree level
    // plus the output stage
    function automatic int calc_lat(input int n_in);
        return clog2(n_in) + 1;
    endfunction

    // Number of values left after lvl halvings; odd leftovers pass through,
    // so the count is ceil(n/2) per level
    function automatic int level_count(input int n_in, input int lvl);
        int c;
        c = n_in;
        for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reduce_stage.sv
`default_nettype none
// ============================================================================
//  Module   : reduce_stage
//  Purpose  : One registered level of the reduction tree. Adjacent pairs are
//             combined with add or xor; an odd leftover is passed through.
//  Revision : 1.0 - initial pipelined release
// ============================================================================
module reduce_stage #(
    parameter int N_VALS = 4,
    parameter int DATA_W = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_en,
    input  logic                                i_clr,
    input  logic                                i_xor,
    input  logic                                i_valid,
    input  logic [N_VALS*DATA_W-1:0]            i_data,
    output logic                                o_valid,
    output logic [((N_VALS+1)/2)*DATA_W-1:0]    o_data
);
    localparam int N_OUT = (N_VALS + 1) / 2;

    logic [N_OUT*DATA_W-1:0] w_comb;
    logic [N_OUT*DATA_W-1:0] r_data;
    logic                    r_valid;

    for (genvar j = 0; j < N_OUT; j++) begin : g_pair
        if (2 * j + 1 < N_VALS) begin : g_op
            logic [DATA_W-1:0] w_a;
            logic [DATA_W-1:0] w_b;
            assign w_a = i_data[(2*j)*DATA_W +: DATA_W];
            assign w_b = i_data[(2*j+1)*DATA_W +: DATA_W];
            assign w_comb[j*DATA_W +: DATA_W] = i_xor ? (w_a ^ w_b) : (w_a + w_b);
        end else begin : g_pass
            assign w_comb[j*DATA_W +: DATA_W] = i_data[(2*j)*DATA_W +: DATA_W];
        end
    end

    // Level register: a clear only kills the valid bit, data is don't-care then
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_data  <= w_comb;
            r_valid <= i_valid;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/custom_instruction_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : custom_instruction_pipe
//  Purpose  : Pipelined N-input SUM/XOR/SUB/ACC reduction unit with a
//             Versat-style start-delay counter and valid tracking.
//  Revision : 1.0 - initial pipelined release
// ============================================================================
module custom_instruction_pipe
    import custom_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int N_IN    = 4,
    parameter int DELAY_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   running,
    input  logic                   run,
    input  logic [1:0]             mode,
    input  logic [DELAY_W-1:0]     delay0,
    input  logic [N_IN*DATA_W-1:0] in_flat,
    output logic [DATA_W-1:0]      out0,
    output logic                   valid0
);
    // out0 trails the sampled operands by LAT running cycles (versat_latency)
    localparam int LAT = calc_lat(N_IN);
    localparam int L   = LAT - 1;

    logic [1:0]             r_mode;
    logic [DELAY_W-1:0]     r_cnt;
    logic                   r_armed;
    logic [N_IN*DATA_W-1:0] w_cond;
    logic                   w_sample;
    logic                   w_is_xor;
    logic [DATA_W-1:0]      w_tree;
    logic                   w_tree_v;
    logic [DATA_W-1:0]      w_acc_sum;
    logic [DATA_W-1:0]      r_acc;
    logic [DATA_W-1:0]      r_out;
    logic                   r_valid;

    // Run latches the configuration; afterwards the counter burns the delay
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode  <= MODE_SUM;
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else if (run) begin
            r_mode  <= mode;
            r_cnt   <= delay0;
            r_armed <= 1'b1;
        end else if (running && r_armed && (r_cnt != '0)) begin
            r_cnt <= r_cnt - DELAY_W'(1);
        end
    end

    // Operands enter the tree every running cycle once the delay has expired
    assign w_sample = running && r_armed && (r_cnt == '0) && !run;
    assign w_is_xor = (r_mode == MODE_XOR);

    // SUB negates every operand but the first so the adder tree yields in0 - rest
    always_comb begin
        w_cond = in_flat;
        if (r_mode == MODE_SUB) begin
            for (int i = 1; i < N_IN; i++) begin
                w_cond[i*DATA_W +: DATA_W] = -in_flat[i*DATA_W +: DATA_W];
            end
        end
    end

    for (genvar k = 0; k < L; k++) begin : g_level
        localparam int C_NI = level_count(N_IN, k);
        localparam int C_NO = level_count(N_IN, k + 1);
        logic [C_NI*DATA_W-1:0] w_in;
        logic                   w_vin;
        logic [C_NO*DATA_W-1:0] w_out;
        logic                   w_vout;

        if (k == 0) begin : g_first
            assign w_in  = w_cond;
            assign w_vin = w_sample;
        end else begin : g_next
            assign w_in  = g_level[k-1].w_out;
            assign w_vin = g_level[k-1].w_vout;
        end

        reduce_stage #(
            .N_VALS (C_NI),
            .DATA_W (DATA_W)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_en    (running),
            .i_clr   (run),
            .i_xor   (w_is_xor),
            .i_valid (w_vin),
            .i_data  (w_in),
            .o_valid (w_vout),
            .o_data  (w_out)
        );
    end

    assign w_tree    = g_level[L-1].w_out;
    assign w_tree_v  = g_level[L-1].w_vout;
    assign w_acc_sum = r_acc + w_tree;

    // Output stage: publish the tree result, or fold it into the accumulator
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
        end else if (run) begin
            r_acc   <= '0;
            r_valid <= 1'b0;
        end else if (running) begin
            if (w_tree_v) begin
                if (r_mode == MODE_ACC) begin
                    r_acc <= w_acc_sum;
                    r_out <= w_acc_sum;
                end else begin
                    r_out <= w_tree;
                end
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out0   = r_out;
    assign valid0 = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_custom_instruction_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_custom_instruction_pipe
//  Purpose  : Scoreboard bench for custom_instruction_pipe: N_IN=4 directed
//             scenarios plus an XOR sweep over N_IN = 2, 3, 5, 8.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_custom_instruction_pipe;
    import custom_unit_pkg::*;

    localparam int C_LAT = 3;   // N_IN = 4: two tree levels plus output stage

    typedef struct {
        logic [31:0] val;
        int          due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         running = 1'b0;
    logic         run = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic [31:0]  delay0 = 32'd0;
    logic [127:0] in_flat = '0;
    logic [31:0]  out0;
    logic         valid0;

    logic         push_exp = 1'b0;
    logic [31:0]  exp_val = 32'd0;

    int           checks = 0;
    int           failures = 0;

    exp_t         q[$];
    int           rc = 0;
    logic         edge_run = 1'b0;

    always #5 clk = ~clk;

    custom_instruction_pipe #(
        .DATA_W  (32),
        .N_IN    (4),
        .DELAY_W (32)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .running (running),
        .run     (run),
        .mode    (mode),
        .delay0  (delay0),
        .in_flat (in_flat),
        .out0    (out0),
        .valid0  (valid0)
    );

    // Expected results enter the queue on the edge that samples the operands
    always @(posedge clk) begin : feed
        exp_t e;
        edge_run <= running;
        if (!rst || run) begin
            q.delete();
        end else if (running) begin
            if (push_exp) begin
                e.val = exp_val;
                e.due = rc + C_LAT;
                q.push_back(e);
            end
            rc <= rc + 1;
        end
    end

    // Monitor: each freshly produced valid0 pops one expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst && edge_run) begin
            if (valid0) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL main_unexpected: out0=%h valid0=1 at cycle %0d, no result outstanding", out0, rc);
                end else begin
                    e = q.pop_front();
                    if (out0 !== e.val || rc != e.due) begin
                        failures++;
                        $display("FAIL main_result: out0=%h at cycle %0d, expected %h at cycle %0d", out0, rc, e.val, e.due);
                    end
                end
            end else if (q.size() != 0 && q[0].due <= rc) begin
                checks++;
                failures++;
                e = q.pop_front();
                $display("FAIL main_missing: valid0=0 at cycle %0d, expected %h", rc, e.val);
            end
        end
    end

    // ---------------- XOR parameter sweep ----------------
    logic         sw_run = 1'b0;
    logic         sw_running = 1'b0;
    logic         sw_push = 1'b0;
    logic [255:0] sw_in [4];

    function automatic logic [31:0] xor_red(input logic [255:0] v, input int n);
        logic [31:0] x;
        x = 32'd0;
        for (int i = 0; i < n; i++) x = x ^ v[i*32 +: 32];
        return x;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int C_N = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 5 : 8;
        localparam int C_L = (g == 0) ? 2 : (g == 1) ? 3 : 4;
        logic [31:0] s_out;
        logic        s_valid;
        exp_t        sq[$];
        int          s_rc = 0;
        logic        s_edge = 1'b0;

        custom_instruction_pipe #(
            .DATA_W  (32),
            .N_IN    (C_N),
            .DELAY_W (32)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .running (sw_running),
            .run     (sw_run),
            .mode    (MODE_XOR),
            .delay0  (32'd0),
            .in_flat (sw_in[g][C_N*32-1:0]),
            .out0    (s_out),
            .valid0  (s_valid)
        );

        always @(posedge clk) begin : s_feed
            exp_t e;
            s_edge <= sw_running;
            if (!rst || sw_run) begin
                sq.delete();
            end else if (sw_running) begin
                if (sw_push) begin
                    e.val = xor_red(sw_in[g], C_N);
                    e.due = s_rc + C_L;
                    sq.push_back(e);
                end
                s_rc <= s_rc + 1;
            end
        end

        always @(negedge clk) begin : s_mon
            exp_t e;
            if (rst && s_edge) begin
                if (s_valid) begin
                    checks++;
                    if (sq.size() == 0) begin
                        failures++;
                        $display("FAIL sweep_n%0d_unexpected: out0=%h at cycle %0d, no result outstanding", C_N, s_out, s_rc);
                    end else begin
                        e = sq.pop_front();
                        if (s_out !== e.val || s_rc != e.due) begin
                            failures++;
                            $display("FAIL sweep_n%0d_result: out0=%h at cycle %0d, expected %h at cycle %0d", C_N, s_out, s_rc, e.val, e.due);
                        end
                    end
                end else if (sq.size() != 0 && sq[0].due <= s_rc) begin
                    checks++;
                    failures++;
                    e = sq.pop_front();
                    $display("FAIL sweep_n%0d_missing: valid0=0 at cycle %0d, expected %h", C_N, s_rc, e.val);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [127:0] ops(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    task automatic cyc(input logic r, input logic rn, input logic [127:0] d,
                       input logic p, input logic [31:0] e);
        run      = r;
        running  = rn;
        in_flat  = d;
        push_exp = p;
        exp_val  = e;
        @(negedge clk);
    endtask

    task automatic start(input logic [1:0] m, input logic [31:0] dly);
        mode   = m;
        delay0 = dly;
        cyc(1'b1, 1'b1, ops(32'hBAD0, 32'hBAD1, 32'hBAD2, 32'hBAD3), 1'b0, 32'd0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        for (int g = 0; g < 4; g++) sw_in[g] = '0;

        // Reset state, with and without running
        repeat (2) @(negedge clk);
        chk("reset_out0", out0, 32'd0);
        chk("reset_valid0", {31'd0, valid0}, 32'd0);
        running = 1'b1;
        @(negedge clk);
        chk("reset_running_valid0", {31'd0, valid0}, 32'd0);
        rst = 1'b1;
        cyc(1'b0, 1'b1, ops(7, 7, 7, 7), 1'b0, 32'd0);   // not armed yet

        // SUM: latency and modulo wrap
        start(MODE_SUM, 32'd0);
        cyc(1'b0, 1'b1, ops(1, 2, 3, 4), 1'b1, 32'd10);
        cyc(1'b0, 1'b1, ops(32'hFFFFFFFF, 2, 0, 0), 1'b1, 32'd1);
        cyc(1'b0, 1'b1, ops(32'h80000000, 32'h80000000, 3, 4), 1'b1, 32'd7);
        repeat (3) cyc(1'b0, 1'b1, '0, 1'b1, 32'd0);

        // SUB
        start(MODE_SUB, 32'd0);
        cyc(1'b0, 1'b1, ops(5, 7, 0, 0), 1'b1, 32'hFFFFFFFE);
        cyc(1'b0, 1'b1, ops(100, 1, 2, 3), 1'b1, 32'd94);
        repeat (3) cyc(1'b0, 1'b1, '0, 1'b1, 32'd0);

        // XOR
        start(MODE_XOR, 32'd0);
        cyc(1'b0, 1'b1, ops(32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFF0000, 1), 1'b1, 32'h0000FFFE);
        cyc(1'b0, 1'b1, ops(32'hA, 32'hA, 5, 5), 1'b1, 32'd0);
        cyc(1'b0, 1'b1, ops(1, 2, 4, 8), 1'b1, 32'hF);
        repeat (3) cyc(1'b0, 1'b1, '0, 1'b1, 32'd0);

        // ACC over four samples, then restart
        start(MODE_ACC, 32'd0);
        cyc(1'b0, 1'b1, ops(1, 1, 1, 1), 1'b1, 32'd4);
        cyc(1'b0, 1'b1, ops(1, 1, 1, 1), 1'b1, 32'd8);
        cyc(1'b0, 1'b1, ops(1, 1, 1, 1), 1'b1, 32'd12);
        cyc(1'b0, 1'b1, ops(1, 1, 1, 1), 1'b1, 32'd16);
        repeat (3) cyc(1'b0, 1'b1, '0, 1'b1, 32'd16);
        start(MODE_ACC, 32'd0);
        cyc(1'b0, 1'b1, ops(1, 1, 1, 1), 1'b1, 32'd4);
        repeat (3) cyc(1'b0, 1'b1, '0, 1'b1, 32'd4);

        // Delay of 5, mode change ignored, stall while a result is on out0
        start(MODE_SUM, 32'd5);
        repeat (5) cyc(1'b0, 1'b1, ops(9, 9, 9, 9), 1'b0, 32'd0);
        mode = MODE_XOR;
        cyc(1'b0, 1'b1, ops(10, 20, 30, 40), 1'b1, 32'd100);
        cyc(1'b0, 1'b1, ops(1, 0, 0, 0), 1'b1, 32'd1);
        cyc(1'b0, 1'b1, '0, 1'b1, 32'd0);
        for (int s = 0; s < 3; s++) begin
            cyc(1'b0, 1'b0, ops(32'hDEAD, 32'hBEEF, 3, 4), 1'b0, 32'd0);
            chk("stall_out0", out0, 32'd100);
            chk("stall_valid0", {31'd0, valid0}, 32'd1);
        end
        repeat (4) cyc(1'b0, 1'b1, '0, 1'b1, 32'd0);

        // Run collides with an emerging result
        start(MODE_SUM, 32'd0);
        cyc(1'b0, 1'b1, ops(2, 2, 2, 2), 1'b1, 32'd8);
        cyc(1'b0, 1'b1, ops(5, 0, 0, 0), 1'b1, 32'd5);
        cyc(1'b0, 1'b1, ops(6, 0, 0, 0), 1'b1, 32'd6);
        chk("pre_collision_out0", out0, 32'd8);
        start(MODE_SUM, 32'd0);
        chk("collision_valid0", {31'd0, valid0}, 32'd0);
        chk("collision_out0_hold", out0, 32'd8);
        repeat (4) cyc(1'b0, 1'b1, ops(3, 0, 0, 0), 1'b1, 32'd3);

        // Asynchronous reset mid-stream
        cyc(1'b0, 1'b1, ops(3, 3, 3, 3), 1'b1, 32'd12);
        cyc(1'b0, 1'b1, ops(3, 3, 3, 3), 1'b1, 32'd12);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_out0", out0, 32'd0);
        chk("async_reset_valid0", {31'd0, valid0}, 32'd0);
        q.delete();
        @(negedge clk);
        cyc(1'b0, 1'b1, ops(4, 4, 4, 4), 1'b0, 32'd0);
        rst = 1'b1;
        for (int s = 0; s < 5; s++) begin
            cyc(1'b0, 1'b1, ops(4, 4, 4, 4), 1'b0, 32'd0);
            chk("post_reset_valid0", {31'd0, valid0}, 32'd0);
        end
        running = 1'b0;

        // XOR sweep across N_IN = 2, 3, 5, 8
        sw_running = 1'b1;
        sw_run = 1'b1;
        @(negedge clk);
        sw_run = 1'b0;
        for (int c = 0; c < 14; c++) begin
            for (int g = 0; g < 4; g++) begin
                for (int w = 0; w < 8; w++) sw_in[g][w*32 +: 32] = $urandom;
            end
            sw_push = 1'b1;
            @(negedge clk);
        end
        sw_running = 1'b0;
        sw_push = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
